// File: rtl/operand_fetch.sv
// Register-read stage between the decoder and EX: drives reg_file read addresses,
// tracks in-flight destinations in a scoreboard, stalls on RAW/WAW and bypasses writeback.
module operand_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int INFO_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_rs1,
  input  logic [ADDR_WIDTH-1:0]      in_rs2,
  input  logic [ADDR_WIDTH-1:0]      in_rd,
  input  logic                       in_rd_wen,
  input  logic [INFO_WIDTH-1:0]      in_info,
  output logic [ADDR_WIDTH-1:0]      rf_raddr1,
  output logic [ADDR_WIDTH-1:0]      rf_raddr2,
  input  logic [DATA_WIDTH-1:0]      rf_rdata1,
  input  logic [DATA_WIDTH-1:0]      rf_rdata2,
  input  logic                       wb_valid,
  input  logic [ADDR_WIDTH-1:0]      wb_addr,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_op1,
  output logic [DATA_WIDTH-1:0]      out_op2,
  output logic [ADDR_WIDTH-1:0]      out_rd,
  output logic                       out_rd_wen,
  output logic [INFO_WIDTH-1:0]      out_info,
  output logic [2**ADDR_WIDTH-1:0]   pending
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic                  wb_hit;
  logic                  clr_rs1, clr_rs2, clr_rd;
  logic                  busy_rs1, busy_rs2, busy_rd;
  logic                  hazard, slot_free, issue;
  logic [DATA_WIDTH-1:0] op1_sel, op2_sel;
  logic [NUM_REGS-1:0]   pending_next;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  // A writeback to x0 never clears anything and is never bypassed.
  assign wb_hit  = wb_valid && (wb_addr != '0);
  assign clr_rs1 = wb_hit && (wb_addr == in_rs1);
  assign clr_rs2 = wb_hit && (wb_addr == in_rs2);
  assign clr_rd  = wb_hit && (wb_addr == in_rd);

  assign busy_rs1 = (in_rs1 != '0) && pending[in_rs1] && !clr_rs1;
  assign busy_rs2 = (in_rs2 != '0) && pending[in_rs2] && !clr_rs2;
  assign busy_rd  = (in_rd  != '0) && pending[in_rd]  && !clr_rd;

  assign hazard    = in_valid && (busy_rs1 || busy_rs2 || (in_rd_wen && busy_rd));
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard;
  assign issue     = in_valid && in_ready;

  // reg_file writes at the edge, so a same-cycle writeback must be forwarded here.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    op1_sel = rf_rdata1;
    op2_sel = rf_rdata2;
    if (in_rs1 == '0)  op1_sel = '0;
    else if (clr_rs1)  op1_sel = wb_data;
    if (in_rs2 == '0)  op2_sel = '0;
    else if (clr_rs2)  op2_sel = wb_data;
  end

  // Clear before set: a new writer issued alongside the old writer's writeback stays pending.
  always_comb begin
    pending_next = pending;
    if (wb_hit) pending_next[wb_addr] = 1'b0;
    if (issue && in_rd_wen && (in_rd != '0)) pending_next[in_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      out_valid  <= 1'b0;
      out_op1    <= '0;
      out_op2    <= '0;
      out_rd     <= '0;
      out_rd_wen <= 1'b0;
      out_info   <= '0;
      pending    <= '0;
    end else begin
      pending <= pending_next;
      if (issue) begin
        out_valid  <= 1'b1;
        out_op1    <= op1_sel;
        out_op2    <= op2_sel;
        out_rd     <= in_rd;
        out_rd_wen <= in_rd_wen;
        out_info   <= in_info;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural reg_file, a table of issue vectors and
// hand-written hazard/backpressure/reset sequences, with a queue scoreboard on the EX side.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_wen;
  logic [31:0] in_info;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_info;
  logic [31:0] pending;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] op1, op2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] info;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        rd_wen;
    logic [31:0] info;
    logic        exp_ready;
    logic [31:0] exp_op1, exp_op2;
  } vec_t;

  always #5 clk = ~clk;

  operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .INFO_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_info(in_info),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .out_info(out_info), .pending(pending)
  );

  // Behavioural reg_file: combinational read, write at the clock edge.
  logic [31:0] regs [32];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_valid && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // EX side: every completed handshake is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_op1",    64'(out_op1),    64'(e.op1));
        check("out_op2",    64'(out_op2),    64'(e.op2));
        check("out_rd",     64'(out_rd),     64'(e.rd));
        check("out_rd_wen", 64'(out_rd_wen), 64'(e.rd_wen));
        check("out_info",   64'(out_info),   64'(e.info));
      end
    end
  end

  task automatic push(input logic [31:0] op1, op2, input logic [4:0] rd, input logic wen,
                      input logic [31:0] info);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.rd = rd; e.rd_wen = wen; e.info = info;
    sb.push_back(e);
  endtask

  task automatic set_in(input logic [4:0] rs1, rs2, rd, input logic wen, input logic [31:0] info);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen; in_info = info;
  endtask

  // Present one instruction and wait (bounded) until it is accepted.
  task automatic issue(input logic [4:0] rs1, rs2, rd, input logic wen, input logic [31:0] info,
                       input logic [31:0] op1, op2);
    int n;
    n = 0;
    set_in(rs1, rs2, rd, wen, info);
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
    else push(op1, op2, rd, wen, info);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_valid = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    tbl[0] = '{5'd1,  5'd2,  5'd3,  1'b1, 32'hA000_0000, 1'b1, 32'd5,         32'd7};
    tbl[1] = '{5'd4,  5'd5,  5'd6,  1'b1, 32'hA000_0001, 1'b1, 32'h104,       32'h105};
    tbl[2] = '{5'd0,  5'd1,  5'd7,  1'b0, 32'hA000_0002, 1'b1, 32'd0,         32'd5};
    tbl[3] = '{5'd2,  5'd0,  5'd0,  1'b1, 32'hA000_0003, 1'b1, 32'd7,         32'd0};
    tbl[4] = '{5'd31, 5'd30, 5'd8,  1'b1, 32'hA000_0004, 1'b1, 32'h11F,       32'h11E};
    tbl[5] = '{5'd9,  5'd9,  5'd9,  1'b0, 32'hA000_0005, 1'b1, 32'h109,       32'h109};
    tbl[6] = '{5'd3,  5'd0,  5'd12, 1'b1, 32'hA000_0006, 1'b0, 32'd0,         32'd0};
    tbl[7] = '{5'd0,  5'd0,  5'd8,  1'b1, 32'hA000_0007, 1'b0, 32'd0,         32'd0};

    rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_wen = 1'b0;
    in_info = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pending",   64'(pending),   64'd0);
    check("rst_out_op1",   64'(out_op1),   64'd0);
    check("rst_out_info",  64'(out_info),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    // Preload registers; writebacks to non-pending registers must leave the scoreboard clear.
    for (int i = 1; i < 32; i++)
      wb(5'(i), (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : 32'h100 + 32'(i));
    @(negedge clk);
    check("preload_pending", 64'(pending), 64'd0);
    @(posedge clk); #1;

    // Table: back-to-back issue with out_ready=1, then a RAW and a WAW entry that must stall.
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rd_wen, tbl[i].info);
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_ready));
      if (in_ready)
        push(tbl[i].exp_op1, tbl[i].exp_op2, tbl[i].rd, tbl[i].rd_wen, tbl[i].info);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("tbl_pending", 64'(pending), 64'h0000_0148);
    @(posedge clk); #1;
    wb(5'd3, 32'h33); wb(5'd6, 32'h66); wb(5'd8, 32'h88);
    @(negedge clk);
    check("tbl_cleared", 64'(pending), 64'd0);
    @(posedge clk); #1;

    // RAW stall resolved by a same-cycle writeback bypass.
    issue(5'd1, 5'd2, 5'd3, 1'b1, 32'hB000_0000, 32'd5, 32'd7);
    set_in(5'd3, 5'd1, 5'd10, 1'b1, 32'hB000_0001);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("raw_stall%0d", c), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
    @(negedge clk);
    check("raw_release", 64'(in_ready), 64'd1);
    if (in_ready) push(32'h1234, 32'd5, 5'd10, 1'b1, 32'hB000_0001);
    @(posedge clk); #1;
    in_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("raw_pending", 64'(pending), 64'h0000_0400);
    @(posedge clk); #1;
    wb(5'd10, 32'hA0);

    // Same-cycle clear and set of x4 leaves the bit set.
    issue(5'd1, 5'd2, 5'd4, 1'b1, 32'hC000_0000, 32'd5, 32'd7);
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    issue(5'd0, 5'd4, 5'd4, 1'b1, 32'hC000_0001, 32'd0, 32'h44);
    wb_valid = 1'b0;
    @(negedge clk);
    check("clr_set_pending", 64'(pending), 64'h0000_0010);
    @(posedge clk); #1;
    wb(5'd4, 32'h45);

    // Backpressure: held output stays stable and blocks the next instruction.
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd0, 1'b0, 32'hD000_0001, 32'd5, 32'd7);
    set_in(5'd9, 5'd1, 5'd13, 1'b1, 32'hD000_0002);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'd0);
      check($sformatf("bp_out_valid%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_out_op1_%0d", c), 64'(out_op1), 64'd5);
      check($sformatf("bp_out_info%0d", c), 64'(out_info), 64'hD000_0001);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 64'(in_ready), 64'd1);
    if (in_ready) push(32'h109, 32'd5, 5'd13, 1'b1, 32'hD000_0002);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wb(5'd13, 32'hD0);

    // x0: every other register pending, x0 sources and destination never stall.
    for (int i = 1; i < 32; i++)
      issue(5'd0, 5'd0, 5'(i), 1'b1, 32'hE000_0000 | 32'(i), 32'd0, 32'd0);
    @(negedge clk);
    check("x0_all_pending", 64'(pending), 64'hFFFF_FFFE);
    @(posedge clk); #1;
    set_in(5'd0, 5'd0, 5'd0, 1'b1, 32'hE000_0100);
    @(negedge clk);
    check("x0_no_stall", 64'(in_ready), 64'd1);
    if (in_ready) push(32'd0, 32'd0, 5'd0, 1'b1, 32'hE000_0100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("x0_pending0", 64'(pending), 64'hFFFF_FFFE);
    @(posedge clk); #1;
    for (int i = 1; i < 32; i++) wb(5'(i), 32'h200 + 32'(i));
    @(negedge clk);
    check("x0_cleared", 64'(pending), 64'd0);
    @(posedge clk); #1;

    // Reset mid-transfer drops the held instruction and the scoreboard.
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd14, 1'b1, 32'hF000_0000, 32'h201, 32'h202);
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pending",   64'(pending),   64'd0);
    check("mid_rst_out_op1",   64'(out_op1),   64'd0);
    check("mid_rst_out_info",  64'(out_info),  64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wb(5'd1, 32'h11);
    issue(5'd1, 5'd0, 5'd5, 1'b1, 32'hF000_0001, 32'h11, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
